sync_fifo_flex: RTL and testbench

- Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags, and a selectable read mode (registered read or first-word-fall-through).
- Successor to the dual-clock UART FIFO. Used for same-domain buffering between the UART RX/TX byte paths and the host-side logic, where no CDC is needed.

---
 rtl/sync_fifo_flex.sv | 128 ++++++++++++
 tb/tb_sync_fifo_flex.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with programmable thresholds, occupancy count, sticky error
// flags and a selectable registered-read or first-word-fall-through read port.
module sync_fifo_flex #(
    parameter int unsigned FIFO_WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_addr       = 4,
    parameter int unsigned ALMOST_FULL_TH  = 12,
    parameter int unsigned ALMOST_EMPTY_TH = 4,
    parameter int unsigned FWFT            = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [FIFO_addr:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = FIFO_addr;
    localparam int unsigned PW = FIFO_addr + 1;
    localparam int unsigned CW = FIFO_addr + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  wr_ok_c, rd_ok_c;
    logic [FIFO_WIDTH-1:0] head_c;

    // Accept decisions, next state and next outputs from registered state
    always_comb begin
        rd_ok_c      = rd_en & ~empty_q;
        wr_ok_c      = wr_en & (~full_q | rd_ok_c);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (wr_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_ok_c) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_ok_c, rd_ok_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d         = (count_d == CW'(FIFO_DEPTH));
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= CW'(ALMOST_FULL_TH));
        almost_empty_d = (count_d <= CW'(ALMOST_EMPTY_TH));
        overflow_d     = (wr_en & ~wr_ok_c) | (overflow_q & ~clr_err);
        underflow_d    = (rd_en & ~rd_ok_c) | (underflow_q & ~clr_err);

        // Next head bypasses memory when it is the word being written this edge
        head_c = (wr_ok_c && (rd_ptr_d == wr_ptr_q)) ? data_in : mem[rd_ptr_d[AW-1:0]];

        if (FWFT != 0) begin
            data_out_d   = head_c;
            data_valid_d = ~empty_d;
        end else begin
            if (rd_ok_c) data_out_d = mem[rd_ptr_q[AW-1:0]];
            data_valid_d = rd_ok_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
        end
    end

    // Storage is never reset; writes are blocked during reset
    always_ff @(posedge clk) begin
        if (reset_n && wr_ok_c) mem[wr_ptr_q[AW-1:0]] <= data_in;
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives one stimulus stream into a registered-read and an FWFT instance and
// checks both against a queue-based model every cycle.
module tb_sync_fifo_flex;

    localparam int DEPTH = 16;
    localparam int AF_TH = 12;
    localparam int AE_TH = 4;

    logic       clk = 1'b0;
    logic       reset_n, wr_en, rd_en, clr_err;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic [4:0] cnt0, cnt1;
    logic       ovf0, ovf1, unf0, unf1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0, m_unf = 1'b0, m_dv0 = 1'b0;
    logic [7:0] m_dout0 = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FWFT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(dout0), .data_valid(dv0),
        .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flex #(.FWFT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .clr_err(clr_err), .data_out(dout1), .data_valid(dv1),
        .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int n = mq.size();
        check_eq("count0", cnt0, n);
        check_eq("count1", cnt1, n);
        check_eq("full0", full0, n == DEPTH);
        check_eq("full1", full1, n == DEPTH);
        check_eq("empty0", empty0, n == 0);
        check_eq("empty1", empty1, n == 0);
        check_eq("afull0", af0, n >= AF_TH);
        check_eq("afull1", af1, n >= AF_TH);
        check_eq("aempty0", ae0, n <= AE_TH);
        check_eq("aempty1", ae1, n <= AE_TH);
        check_eq("ovf0", ovf0, m_ovf);
        check_eq("ovf1", ovf1, m_ovf);
        check_eq("unf0", unf0, m_unf);
        check_eq("unf1", unf1, m_unf);
        check_eq("dout0", dout0, m_dout0);
        check_eq("dvalid0", dv0, m_dv0);
        check_eq("dvalid1", dv1, n != 0);
        if (n != 0) check_eq("dout1_head", dout1, mq[0]);
    endtask

    // One clock: apply inputs, advance the model at the edge, check at negedge
    task automatic step(input bit wr, input logic [7:0] din, input bit rd,
                        input bit clr, input bit rstn);
        int  n;
        bit  rok, wok;
        wr_en = wr; data_in = din; rd_en = rd; clr_err = clr; reset_n = rstn;
        @(posedge clk);
        if (!rstn) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_dv0 = 1'b0; m_dout0 = 8'h00;
        end else begin
            n   = mq.size();
            rok = rd && (n != 0);
            wok = wr && ((n != DEPTH) || rok);
            m_dv0 = rok;
            if (rok) m_dout0 = mq.pop_front();
            if (wok) mq.push_back(din);
            m_ovf = (wr && !wok) || (m_ovf && !clr);
            m_unf = (rd && !rok) || (m_unf && !clr);
        end
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int pw, pr;
        wr_en = 0; rd_en = 0; clr_err = 0; data_in = 0; reset_n = 0;
        @(negedge clk);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check_eq("rst_empty", empty0, 1);
        check_eq("rst_aempty", ae0, 1);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 1);
            if (i == 4) check_eq("aempty_drop", ae0, 0);
            if (i == 11) check_eq("afull_rise", af0, 1);
        end
        check_eq("fill_full", full0, 1);
        check_eq("fill_count", cnt0, 16);

        // Rejected write on full, then clear
        step(1, 8'hAA, 0, 0, 1);
        check_eq("ovf_set", ovf0, 1);
        check_eq("ovf_count", cnt0, 16);
        step(0, 8'h00, 0, 1, 1);
        check_eq("ovf_clr", ovf0, 0);

        // Drain 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 1);
            check_eq("drain_data", dout0, i);
            check_eq("drain_valid", dv0, 1);
        end
        check_eq("drain_empty", empty0, 1);
        step(0, 8'h00, 1, 0, 1);
        check_eq("unf_set", unf0, 1);
        step(0, 8'h00, 0, 1, 1);

        // Simultaneous read/write at full
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 1);
        step(1, 8'h55, 1, 0, 1);
        check_eq("sim_count", cnt0, 16);
        check_eq("sim_ovf", ovf0, 0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 1);
        check_eq("sim_last", dout0, 8'h55);

        // FWFT behaviour on an empty FIFO
        step(1, 8'hA5, 0, 0, 1);
        check_eq("fwft_data", dout1, 8'hA5);
        check_eq("fwft_empty", empty1, 0);
        check_eq("fwft_valid", dv1, 1);
        check_eq("fwft_count", cnt1, 1);
        step(1, 8'h5A, 0, 0, 1);
        step(0, 8'h00, 1, 0, 1);
        check_eq("fwft_step", dout1, 8'h5A);
        step(0, 8'h00, 1, 0, 1);
        check_eq("fwft_drained", empty1, 1);

        // Reset with count=7 and a write pending
        for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 0, 0, 1);
        step(1, 8'h99, 0, 0, 0);
        check_eq("rmid_count", cnt0, 0);
        check_eq("rmid_valid", dv0, 0);
        step(1, 8'h3C, 0, 0, 1);
        check_eq("rmid_fwft", dout1, 8'h3C);
        step(0, 8'h00, 1, 0, 1);
        check_eq("rmid_read", dout0, 8'h3C);

        // Randomised traffic with varying write/read pressure
        pw = 50; pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                pw = $urandom_range(10, 90);
                pr = $urandom_range(10, 90);
            end
            step(($urandom % 100) < pw, 8'($urandom), ($urandom % 100) < pr,
                 ($urandom % 20) == 0, ($urandom % 500) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
